// File: rtl/multi_lane_write_buffer_if.sv
// Bus between the controlling logic and the multi-lane serial transmit buffer.
// The master side issues transfers; the slave side (the buffer) drives lanes and status.
interface multi_lane_write_buffer_if #(
    parameter int BUF_SIZE = 16,
    parameter int LANES    = 4
);
    localparam int CTR_SIZE = $clog2(BUF_SIZE + 1);

    logic                start;
    logic                write_sig;
    logic                abort;
    logic                lsb_first;
    logic [BUF_SIZE-1:0] data_in;
    logic [CTR_SIZE-1:0] write_count;
    logic [LANES-1:0]    data_out;
    logic                busy;
    logic                done_sig;
    logic                aborted;

    modport master (
        output start, write_sig, abort, lsb_first, data_in, write_count,
        input  data_out, busy, done_sig, aborted
    );

    modport slave (
        input  start, write_sig, abort, lsb_first, data_in, write_count,
        output data_out, busy, done_sig, aborted
    );
endinterface

// File: rtl/multi_lane_write_buffer.sv
// Serial transmit buffer: shifts a latched word out over LANES parallel lanes, one symbol
// per write strobe, with bit-order select, idle padding of a partial final symbol, and abort.
module multi_lane_write_buffer #(
    parameter int BUF_SIZE   = 16,
    parameter int LANES      = 4,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input logic                      sys_clk,
    input logic                      rst_n,
    multi_lane_write_buffer_if.slave bus
);
    localparam int                  CTR_SIZE = $clog2(BUF_SIZE + 1);
    localparam int                  LANE_SH  = $clog2(LANES);
    localparam logic [CTR_SIZE-1:0] BUF_N    = CTR_SIZE'(BUF_SIZE);
    localparam logic [LANES-1:0]    IDLE_SYM = {LANES{IDLE_LEVEL}};

    typedef enum logic [1:0] {IDLE = 2'b01, WRITE = 2'b10} state_t;

    state_t              state_q, state_d;
    logic [BUF_SIZE-1:0] shreg_q, shreg_d;
    logic                lsb_q, lsb_d;
    logic [CTR_SIZE-1:0] ctr_q, ctr_d;
    logic [LANES-1:0]    data_out_q, data_out_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                aborted_q, aborted_d;

    logic [CTR_SIZE-1:0] n_clamp;
    logic [CTR_SIZE:0]   n_round;
    logic [CTR_SIZE-1:0] sym_m1;
    logic [BUF_SIZE-1:0] merged;
    logic                accept;

    // Bits past the requested count are replaced by the idle level up front, so padding
    // falls out of the ordinary shift and no stale data can ever reach the pins.
    function automatic logic [BUF_SIZE-1:0] merge_word(input logic [BUF_SIZE-1:0] data,
                                                       input logic [CTR_SIZE-1:0] n,
                                                       input logic              lsb);
        logic [BUF_SIZE-1:0] ones;
        logic [BUF_SIZE-1:0] mask;
        ones = '1;
        mask = lsb ? ~(ones << n) : ~(ones >> n);
        return (data & mask) | (~mask & {BUF_SIZE{IDLE_LEVEL}});
    endfunction

    function automatic logic [LANES-1:0] head_sym(input logic [BUF_SIZE-1:0] w, input logic lsb);
        return lsb ? w[LANES-1:0] : w[BUF_SIZE-1 -: LANES];
    endfunction

    function automatic logic [BUF_SIZE-1:0] advance(input logic [BUF_SIZE-1:0] w, input logic lsb);
        return lsb ? {IDLE_SYM, w[BUF_SIZE-1:LANES]} : {w[BUF_SIZE-LANES-1:0], IDLE_SYM};
    endfunction

    assign n_clamp = (bus.write_count > BUF_N) ? BUF_N : bus.write_count;
    assign n_round = {1'b0, n_clamp} + (CTR_SIZE + 1)'(LANES - 1);
    assign sym_m1  = CTR_SIZE'(n_round >> LANE_SH) - CTR_SIZE'(1);
    assign merged  = merge_word(bus.data_in, n_clamp, bus.lsb_first);
    assign accept  = bus.start && (n_clamp != '0);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            lsb_q      <= 1'b0;
            ctr_q      <= '0;
            data_out_q <= IDLE_SYM;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            lsb_q      <= lsb_d;
            ctr_q      <= ctr_d;
            data_out_q <= data_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = accept ? WRITE : IDLE;
            WRITE:   state_d = (bus.abort || (bus.write_sig && ctr_q == '0)) ? IDLE : WRITE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shreg_d    = shreg_q;
        lsb_d      = lsb_q;
        ctr_d      = ctr_q;
        data_out_d = data_out_q;
        busy_d     = busy_q;
        done_d     = done_q;
        aborted_d  = aborted_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    lsb_d      = bus.lsb_first;
                    ctr_d      = sym_m1;
                    data_out_d = head_sym(merged, bus.lsb_first);
                    shreg_d    = advance(merged, bus.lsb_first);
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    aborted_d  = 1'b0;
                end
            end
            WRITE: begin
                // Abort wins over a coincident strobe.
                if (bus.abort) begin
                    data_out_d = IDLE_SYM;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    aborted_d  = 1'b1;
                end else if (bus.write_sig) begin
                    if (ctr_q != '0) begin
                        data_out_d = head_sym(shreg_q, lsb_q);
                        shreg_d    = advance(shreg_q, lsb_q);
                        ctr_d      = ctr_q - CTR_SIZE'(1);
                    end else begin
                        data_out_d = IDLE_SYM;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                    end
                end
            end
            default: begin
                shreg_d    = '0;
                lsb_d      = 1'b0;
                ctr_d      = '0;
                data_out_d = IDLE_SYM;
                busy_d     = 1'b0;
                done_d     = 1'b1;
                aborted_d  = 1'b0;
            end
        endcase
    end

    assign bus.data_out = data_out_q;
    assign bus.busy     = busy_q;
    assign bus.done_sig = done_q;
    assign bus.aborted  = aborted_q;
endmodule

// File: tb/tb_multi_lane_write_buffer.sv
// Bench for multi_lane_write_buffer: directed scenarios on a quad-lane and a single-lane
// instance, then randomized transfers checked against a per-bit stream model.
module tb_multi_lane_write_buffer;
    logic sys_clk = 1'b0;
    logic rst_n   = 1'b0;
    int   n_cmp   = 0;
    int   n_err   = 0;

    always #5 sys_clk = ~sys_clk;

    multi_lane_write_buffer_if #(.BUF_SIZE(16), .LANES(4)) bus ();
    multi_lane_write_buffer_if #(.BUF_SIZE(8),  .LANES(1)) bus1 ();

    multi_lane_write_buffer #(.BUF_SIZE(16), .LANES(4), .IDLE_LEVEL(1'b0)) dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    multi_lane_write_buffer #(.BUF_SIZE(8), .LANES(1), .IDLE_LEVEL(1'b0)) dut1 (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .bus     (bus1)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic start_main(input logic [15:0] d, input int cnt, input logic lsb);
        bus.data_in     = d;
        bus.write_count = 5'(cnt);
        bus.lsb_first   = lsb;
        bus.start       = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic strobe_main();
        bus.write_sig = 1'b1;
        tick();
        bus.write_sig = 1'b0;
    endtask

    // Expected symbol k: lane j carries stream bit p, where the stream is the first n bits
    // of d in the chosen order; bits at or past n read as the idle level (0).
    function automatic logic [3:0] model_sym(input logic [15:0] d, input int n, input bit lsb,
                                             input int k);
        logic [3:0] s;
        for (int j = 0; j < 4; j++) begin
            int p;
            p = lsb ? (k * 4 + j) : (k * 4 + (3 - j));
            if (p < n) s[j] = lsb ? d[p] : d[15 - p];
            else       s[j] = 1'b0;
        end
        return s;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_cmp++; if (bus.data_out !== 4'h0) begin n_err++; $display("FAIL reset_data_out: got %h want 0", bus.data_out); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.done_sig !== 1'b1) begin n_err++; $display("FAIL reset_done: got %b want 1", bus.done_sig); end
        n_cmp++; if (bus.aborted !== 1'b0) begin n_err++; $display("FAIL reset_aborted: got %b want 0", bus.aborted); end
        n_cmp++; if (bus1.done_sig !== 1'b1) begin n_err++; $display("FAIL reset_done1: got %b want 1", bus1.done_sig); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_lane();
        logic [7:0] pat;
        pat = 8'hA5;
        bus1.data_in     = pat;
        bus1.write_count = 4'd8;
        bus1.lsb_first   = 1'b0;
        bus1.start       = 1'b1;
        tick();
        bus1.start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (bus1.data_out !== pat[7 - k] || bus1.busy !== 1'b1) begin
                n_err++;
                $display("FAIL single_lane_bit%0d: got %b busy %b want %b busy 1", k, bus1.data_out, bus1.busy, pat[7 - k]);
            end
            bus1.write_sig = 1'b1;
            tick();
            bus1.write_sig = 1'b0;
        end
        n_cmp++;
        if (bus1.done_sig !== 1'b1 || bus1.busy !== 1'b0 || bus1.data_out !== 1'b0) begin
            n_err++;
            $display("FAIL single_lane_end: got done %b busy %b out %b want 1 0 0", bus1.done_sig, bus1.busy, bus1.data_out);
        end
    endtask

    task automatic test_lsb_quad();
        logic [3:0] e [4];
        e = '{4'h4, 4'h3, 4'h2, 4'h1};
        start_main(16'h1234, 16, 1'b1);
        n_cmp++; if (bus.done_sig !== 1'b0) begin n_err++; $display("FAIL lsb_done_low: got %b want 0", bus.done_sig); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (bus.data_out !== e[k]) begin n_err++; $display("FAIL lsb_sym%0d: got %h want %h", k, bus.data_out, e[k]); end
            strobe_main();
        end
        n_cmp++;
        if (bus.done_sig !== 1'b1 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL lsb_end: got done %b busy %b want 1 0", bus.done_sig, bus.busy);
        end
    endtask

    task automatic test_partial();
        start_main(16'hB400, 6, 1'b0);
        n_cmp++; if (bus.data_out !== 4'hB) begin n_err++; $display("FAIL partial_sym0: got %h want b", bus.data_out); end
        strobe_main();
        n_cmp++; if (bus.data_out !== 4'h4) begin n_err++; $display("FAIL partial_sym1: got %h want 4", bus.data_out); end
        strobe_main();
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.done_sig !== 1'b1 || bus.data_out !== 4'h0) begin
            n_err++;
            $display("FAIL partial_end: got busy %b done %b out %h want 0 1 0", bus.busy, bus.done_sig, bus.data_out);
        end
    endtask

    task automatic test_count_edges();
        start_main(16'hFFFF, 0, 1'b0);
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.done_sig !== 1'b1 || bus.data_out !== 4'h0) begin
            n_err++;
            $display("FAIL count0: got busy %b done %b out %h want 0 1 0", bus.busy, bus.done_sig, bus.data_out);
        end
        start_main(16'hFFFF, 31, 1'b0);
        // start with new data while busy must be ignored
        bus.data_in     = 16'h0000;
        bus.write_count = 5'd4;
        bus.start       = 1'b1;
        tick();
        bus.start = 1'b0;
        n_cmp++; if (bus.data_out !== 4'hF || bus.busy !== 1'b1) begin n_err++; $display("FAIL start_in_write: got %h busy %b want f 1", bus.data_out, bus.busy); end
        for (int k = 1; k < 4; k++) begin
            strobe_main();
            n_cmp++;
            if (bus.data_out !== 4'hF || bus.busy !== 1'b1) begin
                n_err++;
                $display("FAIL count31_sym%0d: got %h busy %b want f 1", k, bus.data_out, bus.busy);
            end
        end
        strobe_main();
        n_cmp++; if (bus.busy !== 1'b0 || bus.done_sig !== 1'b1) begin n_err++; $display("FAIL count31_end: got busy %b done %b want 0 1", bus.busy, bus.done_sig); end
    endtask

    task automatic test_abort();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        n_cmp++; if (bus.aborted !== 1'b0) begin n_err++; $display("FAIL abort_idle: got %b want 0", bus.aborted); end
        start_main(16'h1234, 16, 1'b0);
        strobe_main();
        n_cmp++; if (bus.data_out !== 4'h2) begin n_err++; $display("FAIL abort_pre: got %h want 2", bus.data_out); end
        bus.abort     = 1'b1;
        bus.write_sig = 1'b1;
        tick();
        bus.abort     = 1'b0;
        bus.write_sig = 1'b0;
        n_cmp++;
        if (bus.data_out !== 4'h0 || bus.aborted !== 1'b1 || bus.done_sig !== 1'b1 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL abort: got out %h ab %b done %b busy %b want 0 1 1 0", bus.data_out, bus.aborted, bus.done_sig, bus.busy);
        end
        start_main(16'hB400, 6, 1'b0);
        n_cmp++; if (bus.aborted !== 1'b0 || bus.data_out !== 4'hB) begin n_err++; $display("FAIL abort_clear: got ab %b out %h want 0 b", bus.aborted, bus.data_out); end
        strobe_main();
        strobe_main();
    endtask

    task automatic test_async_reset();
        start_main(16'h1234, 16, 1'b0);
        strobe_main();
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus.data_out !== 4'h0 || bus.busy !== 1'b0 || bus.done_sig !== 1'b1 || bus.aborted !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: got out %h busy %b done %b ab %b want 0 0 1 0", bus.data_out, bus.busy, bus.done_sig, bus.aborted);
        end
        tick();
        rst_n = 1'b1;
        tick();
        start_main(16'h1234, 8, 1'b1);
        n_cmp++; if (bus.data_out !== 4'h4) begin n_err++; $display("FAIL post_reset_sym0: got %h want 4", bus.data_out); end
        strobe_main();
        n_cmp++; if (bus.data_out !== 4'h3) begin n_err++; $display("FAIL post_reset_sym1: got %h want 3", bus.data_out); end
        strobe_main();
        n_cmp++; if (bus.done_sig !== 1'b1 || bus.busy !== 1'b0) begin n_err++; $display("FAIL post_reset_end: got done %b busy %b want 1 0", bus.done_sig, bus.busy); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 60; t++) begin
            logic [15:0] d;
            int          cnt, n, s, abort_at;
            bit          lsb, was_aborted;
            d        = 16'($urandom);
            cnt      = $urandom_range(0, 31);
            lsb      = 1'($urandom_range(0, 1));
            n        = (cnt > 16) ? 16 : cnt;
            s        = (n + 3) / 4;
            abort_at = ($urandom_range(0, 3) == 0 && s > 0) ? $urandom_range(0, s - 1) : -1;
            was_aborted = 1'b0;
            start_main(d, cnt, lsb);
            if (n == 0) begin
                n_cmp++;
                if (bus.busy !== 1'b0 || bus.done_sig !== 1'b1 || bus.data_out !== 4'h0) begin
                    n_err++;
                    $display("FAIL rand%0d_zero: got busy %b done %b out %h want 0 1 0", t, bus.busy, bus.done_sig, bus.data_out);
                end
                continue;
            end
            for (int k = 0; k < s; k++) begin
                n_cmp++;
                if (bus.data_out !== model_sym(d, n, lsb, k) || bus.busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL rand%0d_sym%0d: got %h busy %b want %h busy 1 (d=%h n=%0d lsb=%0d)",
                             t, k, bus.data_out, bus.busy, model_sym(d, n, lsb, k), d, n, lsb);
                end
                bus.data_in     = 16'($urandom);
                bus.write_count = 5'($urandom);
                bus.lsb_first   = 1'($urandom);
                if (abort_at == k) begin
                    bus.abort     = 1'b1;
                    bus.write_sig = 1'($urandom);
                    tick();
                    bus.abort     = 1'b0;
                    bus.write_sig = 1'b0;
                    n_cmp++;
                    if (bus.aborted !== 1'b1 || bus.data_out !== 4'h0 || bus.done_sig !== 1'b1) begin
                        n_err++;
                        $display("FAIL rand%0d_abort: got ab %b out %h done %b want 1 0 1", t, bus.aborted, bus.data_out, bus.done_sig);
                    end
                    was_aborted = 1'b1;
                    break;
                end
                repeat ($urandom_range(0, 2)) begin
                    bus.start = 1'($urandom);
                    tick();
                    bus.start = 1'b0;
                    n_cmp++;
                    if (bus.data_out !== model_sym(d, n, lsb, k)) begin
                        n_err++;
                        $display("FAIL rand%0d_hold%0d: got %h want %h", t, k, bus.data_out, model_sym(d, n, lsb, k));
                    end
                end
                strobe_main();
            end
            if (!was_aborted) begin
                n_cmp++;
                if (bus.data_out !== 4'h0 || bus.done_sig !== 1'b1 || bus.busy !== 1'b0 || bus.aborted !== 1'b0) begin
                    n_err++;
                    $display("FAIL rand%0d_end: got out %h done %b busy %b ab %b want 0 1 0 0",
                             t, bus.data_out, bus.done_sig, bus.busy, bus.aborted);
                end
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;  bus.write_sig = 1'b0;  bus.abort = 1'b0;  bus.lsb_first = 1'b0;
        bus.data_in = '0;  bus.write_count = '0;
        bus1.start = 1'b0; bus1.write_sig = 1'b0; bus1.abort = 1'b0; bus1.lsb_first = 1'b0;
        bus1.data_in = '0; bus1.write_count = '0;
        test_reset();
        test_single_lane();
        test_lsb_quad();
        test_partial();
        test_count_edges();
        test_abort();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
